// File: rtl/hdmi_packet_pkg.sv
// Shared HDMI data-island packet definitions: type codes and requester enum.
package hdmi_packet_pkg;

    // HDMI packet type codes carried in the packet header byte 0.
    localparam logic [7:0] PktNull    = 8'h00;
    localparam logic [7:0] PktAcr     = 8'h01;
    localparam logic [7:0] PktAudio   = 8'h02;
    localparam logic [7:0] PktAvi     = 8'h82;
    localparam logic [7:0] PktSpd     = 8'h83;
    localparam logic [7:0] PktAudioIf = 8'h84;

    // Requesters competing for a data-island slot, in no particular order.
    typedef enum logic [2:0] {
        ReqNull,
        ReqAcr,
        ReqAudio,
        ReqAvi,
        ReqAudioIf,
        ReqSpd
    } requester_e;

    // Map a requester to the packet type it transmits.
    function automatic logic [7:0] packet_code(requester_e req);
        logic [7:0] code;
        case (req)
            ReqAcr:     code = PktAcr;
            ReqAudio:   code = PktAudio;
            ReqAvi:     code = PktAvi;
            ReqAudioIf: code = PktAudioIf;
            ReqSpd:     code = PktSpd;
            default:    code = PktNull;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/data_island_scheduler.sv
// Data-island slot scheduler: collects packet requests, grants one per
// accepted slot by fixed priority and holds the slot busy for one packet.
module data_island_scheduler
    import hdmi_packet_pkg::*;
#(
    parameter int unsigned PACKET_CYCLES = 32,
    parameter bit          SPD_ENABLE    = 1'b1
) (
    input  logic       clk_pixel,
    input  logic       reset,
    input  logic       packet_enable,
    input  logic       frame_start,
    input  logic       acr_toggle,
    input  logic       audio_req,
    output logic [7:0] packet_type,
    output logic       acr_ack,
    output logic       audio_ack,
    output logic       avi_ack,
    output logic       audio_if_ack,
    output logic       spd_ack,
    output logic       busy,
    output logic       overrun,
    output logic       acr_dropped
);

    localparam int unsigned   CntW    = (PACKET_CYCLES > 1) ? $clog2(PACKET_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(PACKET_CYCLES - 1);

    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StSend = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            acr_toggle_q;
    logic            acr_pend_q, acr_pend_d;
    logic            avi_pend_q, avi_pend_d;
    logic            aif_pend_q, aif_pend_d;
    logic            spd_pend_q, spd_pend_d;
    logic            overrun_q, overrun_d;
    logic            acr_dropped_q, acr_dropped_d;
    logic [7:0]      packet_type_q, packet_type_d;
    logic            acr_ack_q, audio_ack_q, avi_ack_q, aif_ack_q, spd_ack_q;

    logic            in_send;
    logic            send_last;
    logic            accept;
    logic            acr_edge;
    requester_e      winner;
    logic            grant_acr, grant_audio, grant_avi, grant_aif, grant_spd;

    assign in_send   = (state_q == StSend);
    // The final SEND cycle doubles as the hand-off cycle, so a slot pulse
    // exactly PACKET_CYCLES after the previous one is taken without a gap.
    assign send_last = in_send && (cnt_q == CntLast);
    assign accept    = packet_enable && (!in_send || send_last);
    assign acr_edge  = acr_toggle ^ acr_toggle_q;

    // Fixed-priority pick among the live requests; audio is a plain level.
    always_comb begin
        winner = ReqNull;
        if (acr_pend_q) begin
            winner = ReqAcr;
        end else if (audio_req) begin
            winner = ReqAudio;
        end else if (avi_pend_q) begin
            winner = ReqAvi;
        end else if (aif_pend_q) begin
            winner = ReqAudioIf;
        end else if (SPD_ENABLE && spd_pend_q) begin
            winner = ReqSpd;
        end
    end

    assign grant_acr   = accept && (winner == ReqAcr);
    assign grant_audio = accept && (winner == ReqAudio);
    assign grant_avi   = accept && (winner == ReqAvi);
    assign grant_aif   = accept && (winner == ReqAudioIf);
    assign grant_spd   = accept && (winner == ReqSpd);

    // Pending flags: a grant clears, a new request in the same cycle re-sets.
    always_comb begin
        acr_pend_d    = (acr_pend_q & ~grant_acr) | acr_edge;
        avi_pend_d    = (avi_pend_q & ~grant_avi) | frame_start;
        aif_pend_d    = (aif_pend_q & ~grant_aif) | frame_start;
        spd_pend_d    = (spd_pend_q & ~grant_spd) | (frame_start & SPD_ENABLE);
        acr_dropped_d = acr_dropped_q | (acr_edge & acr_pend_q & ~grant_acr);
        overrun_d     = overrun_q | (packet_enable & in_send & ~send_last);
    end

    // Slot FSM: IDLE until a slot is accepted, then SEND for PACKET_CYCLES.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StSend;
                    cnt_d   = '0;
                end
            end
            StSend: begin
                if (accept) begin
                    cnt_d = '0;
                end else if (send_last) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // Packet type is captured on acceptance and held until the next one.
    always_comb begin
        packet_type_d = packet_type_q;
        if (accept) begin
            packet_type_d = packet_code(winner);
        end
    end

    // State, flags and registered outputs.
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            acr_toggle_q  <= 1'b0;
            acr_pend_q    <= 1'b0;
            avi_pend_q    <= 1'b0;
            aif_pend_q    <= 1'b0;
            spd_pend_q    <= 1'b0;
            overrun_q     <= 1'b0;
            acr_dropped_q <= 1'b0;
            packet_type_q <= PktNull;
            acr_ack_q     <= 1'b0;
            audio_ack_q   <= 1'b0;
            avi_ack_q     <= 1'b0;
            aif_ack_q     <= 1'b0;
            spd_ack_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            acr_toggle_q  <= acr_toggle;
            acr_pend_q    <= acr_pend_d;
            avi_pend_q    <= avi_pend_d;
            aif_pend_q    <= aif_pend_d;
            spd_pend_q    <= spd_pend_d;
            overrun_q     <= overrun_d;
            acr_dropped_q <= acr_dropped_d;
            packet_type_q <= packet_type_d;
            acr_ack_q     <= grant_acr;
            audio_ack_q   <= grant_audio;
            avi_ack_q     <= grant_avi;
            aif_ack_q     <= grant_aif;
            spd_ack_q     <= grant_spd;
        end
    end

    assign packet_type  = packet_type_q;
    assign acr_ack      = acr_ack_q;
    assign audio_ack    = audio_ack_q;
    assign avi_ack      = avi_ack_q;
    assign audio_if_ack = aif_ack_q;
    assign spd_ack      = spd_ack_q;
    assign busy         = in_send;
    assign overrun      = overrun_q;
    assign acr_dropped  = acr_dropped_q;

endmodule

// File: tb/tb_data_island_scheduler.sv
// Directed bench for data_island_scheduler with hand-computed expectations.
module tb_data_island_scheduler;

    localparam int unsigned PacketCycles = 32;

    // Ack vector order: {acr, audio, avi, audio_if, spd}
    localparam logic [4:0] AckNone  = 5'b00000;
    localparam logic [4:0] AckAcr   = 5'b10000;
    localparam logic [4:0] AckAudio = 5'b01000;
    localparam logic [4:0] AckAvi   = 5'b00100;
    localparam logic [4:0] AckAif   = 5'b00010;
    localparam logic [4:0] AckSpd   = 5'b00001;

    logic       clk = 1'b0;
    logic       reset;
    logic       packet_enable;
    logic       frame_start;
    logic       acr_toggle;
    logic       audio_req;
    logic [7:0] packet_type;
    logic       acr_ack, audio_ack, avi_ack, audio_if_ack, spd_ack;
    logic       busy, overrun, acr_dropped;

    int vectors     = 0;
    int miscompares = 0;

    data_island_scheduler #(
        .PACKET_CYCLES (PacketCycles),
        .SPD_ENABLE    (1'b1)
    ) dut (
        .clk_pixel     (clk),
        .reset         (reset),
        .packet_enable (packet_enable),
        .frame_start   (frame_start),
        .acr_toggle    (acr_toggle),
        .audio_req     (audio_req),
        .packet_type   (packet_type),
        .acr_ack       (acr_ack),
        .audio_ack     (audio_ack),
        .avi_ack       (avi_ack),
        .audio_if_ack  (audio_if_ack),
        .spd_ack       (spd_ack),
        .busy          (busy),
        .overrun       (overrun),
        .acr_dropped   (acr_dropped)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs are driven and outputs sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic gap();
        repeat (PacketCycles - 1) tick();
    endtask

    function automatic logic [31:0] acks();
        return 32'({acr_ack, audio_ack, avi_ack, audio_if_ack, spd_ack});
    endfunction

    task automatic pulse_pe();
        packet_enable = 1'b1;
        tick();
        packet_enable = 1'b0;
    endtask

    task automatic slot(input string tag, input logic [7:0] exp_type, input logic [4:0] exp_ack);
        pulse_pe();
        check({tag, "_type"}, 32'(packet_type), 32'(exp_type));
        check({tag, "_ack"}, acks(), 32'(exp_ack));
        check({tag, "_busy"}, 32'(busy), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        reset         = 1'b1;
        packet_enable = 1'b0;
        frame_start   = 1'b0;
        acr_toggle    = 1'b0;
        audio_req     = 1'b0;
        tick();
        tick();
        check("rst_type", 32'(packet_type), 32'h00);
        check("rst_ack", acks(), 32'(AckNone));
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_flags", 32'({overrun, acr_dropped}), 32'd0);
        reset = 1'b0;
        tick();

        // Single ACR request, then measure busy length.
        acr_toggle = 1'b1;
        tick();
        slot("acr1", 8'h01, AckAcr);
        n = 0;
        while (busy && n < 100) begin
            if (n == 1) check("acr1_ackpulse", acks(), 32'(AckNone));
            n++;
            tick();
        end
        check("busy_len", 32'(n), 32'(PacketCycles));

        // InfoFrames in priority order, slots exactly one packet apart.
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        slot("if_avi", 8'h82, AckAvi);
        gap();
        slot("if_aif", 8'h84, AckAif);
        gap();
        slot("if_spd", 8'h83, AckSpd);
        gap();
        slot("if_null", 8'h00, AckNone);
        check("b2b_overrun", 32'(overrun), 32'd0);
        wait_idle("if");

        // ACR beats audio beats AVI.
        acr_toggle  = 1'b0;
        frame_start = 1'b1;
        audio_req   = 1'b1;
        tick();
        frame_start = 1'b0;
        slot("pri_acr", 8'h01, AckAcr);
        gap();
        slot("pri_audio", 8'h02, AckAudio);
        audio_req = 1'b0;
        gap();
        slot("pri_avi", 8'h82, AckAvi);
        wait_idle("pri");

        // Slot pulse while busy is ignored and flags overrun.
        slot("ovr_first", 8'h84, AckAif);
        repeat (9) tick();
        pulse_pe();
        check("ovr_type", 32'(packet_type), 32'h84);
        check("ovr_ack", acks(), 32'(AckNone));
        check("ovr_flag", 32'(overrun), 32'd1);
        wait_idle("ovr");
        check("ovr_sticky", 32'(overrun), 32'd1);

        // Two ACR edges with no slot between: one grant, dropped flagged.
        acr_toggle = 1'b1;
        tick();
        acr_toggle = 1'b0;
        tick();
        check("drop_flag", 32'(acr_dropped), 32'd1);
        slot("drop_acr", 8'h01, AckAcr);
        wait_idle("drop");
        slot("drop_next", 8'h83, AckSpd);

        // Reset 15 cycles into SEND, with fresh requests pending.
        repeat (5) tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        repeat (9) tick();
        reset = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_type", 32'(packet_type), 32'h00);
        check("arst_flags", 32'({overrun, acr_dropped}), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        slot("arst_null", 8'h00, AckNone);
        wait_idle("arst");

        // acr_toggle high at reset release yields one ACR request.
        reset      = 1'b1;
        acr_toggle = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        slot("rel_acr", 8'h01, AckAcr);
        wait_idle("rel");

        // ACR edge in the grant cycle re-arms without a drop.
        acr_toggle = 1'b0;
        tick();
        packet_enable = 1'b1;
        acr_toggle    = 1'b1;
        tick();
        packet_enable = 1'b0;
        check("coin_type", 32'(packet_type), 32'h01);
        check("coin_ack", acks(), 32'(AckAcr));
        check("coin_drop", 32'(acr_dropped), 32'd0);
        wait_idle("coin");
        slot("coin_acr2", 8'h01, AckAcr);
        check("coin_drop2", 32'(acr_dropped), 32'd0);
        wait_idle("coin2");
        slot("coin_null", 8'h00, AckNone);
        wait_idle("coin3");

        // frame_start in the AVI grant cycle keeps AVI pending.
        frame_start = 1'b1;
        tick();
        packet_enable = 1'b1;
        tick();
        packet_enable = 1'b0;
        frame_start   = 1'b0;
        check("fs_avi1", 32'(packet_type), 32'h82);
        wait_idle("fs");
        slot("fs_avi2", 8'h82, AckAvi);
        gap();
        slot("fs_aif", 8'h84, AckAif);
        wait_idle("end");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
